fmul_arbiter: RTL and testbench
===============================

Name: fmul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one pipelined single-precision multiplier (2 register stages; result valid 2 clocks after operands are sampled) among N requesters.
- Each cycle it grants at most one request, drives the granted operands to the multiplier, and tags the issue with the requester ID.
- When the result emerges, it returns the registered result and error flag to the originating requester.
- An enable/drain FSM allows quiescing the multiplier; a saturating counter tracks error results.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, requester-ID width; must satisfy 2^IDW >= N.
- LAT, 2, multiplier latency in clocks from operand sample to valid C.
- ECW, 16, error counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  1 = issue allowed; 0 = stop granting and drain.
- req  in  N  per-requester request; level, held until granted.
- req_a  in  32*N  operand A; requester i occupies bits [32i+31:32i].
- req_b  in  32*N  operand B, packed the same way.
- gnt  out  N  one-hot grant, combinational; request consumed in this cycle.
- mul_a  out  32  to multiplier A; combinational mux of the granted req_a, else 0.
- mul_b  out  32  to multiplier B; combinational mux of the granted req_b, else 0.
- mul_c  in  32  multiplier result C.
- mul_err  in  1  multiplier error_flag.
- rsp_valid  out  N  one-hot, 1-cycle result strobe (registered).
- rsp_data  out  32  result; valid only while rsp_valid != 0.
- rsp_err  out  1  error flag qualified by rsp_valid.
- idle  out  1  registered; 1 when state = STOP.
- inflight  out  2  registered count of issued operations without a response yet (0..LAT).
- err_cnt  out  ECW  saturating count of responses with rsp_err = 1.

Behaviour:
- Reset (async, rst_n = 0):
  - state = STOP; rr_ptr = 0; tag pipeline valids = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0, inflight = 0, err_cnt = 0.
  - idle = 1; gnt = 0, so mul_a = mul_b = 0.
  - Operations in flight at reset are dropped and produce no response. The multiplier shares rst_n.
- FSM states:
  - STOP: no grants. Go to RUN when en = 1.
  - RUN: grants allowed. Go to DRAIN when en = 0.
  - DRAIN: no grants. Go to STOP when the tag pipeline is empty and no response is pending. Go back to RUN if en = 1 (takes priority).
  - Grant is a combinational function of the current state, so the cycle in which en falls can still grant if state = RUN.
- Arbitration:
  - In RUN with req != 0, grant the first set bit searching from rr_ptr upward, wrapping modulo N.
  - On a grant to i, rr_ptr <= (i+1) mod N; otherwise rr_ptr holds.
  - At most one grant per cycle. The multiplier accepts every cycle, so back-to-back issue is allowed (throughput 1 per clock).
- Tag pipeline:
  - LAT stages of {valid, id}. Stage0 captures {|gnt, encoded id} at the grant edge; each later stage shifts every edge.
  - While the last stage is valid, mul_c and mul_err belong to that id.
  - At the next edge: rsp_valid <= onehot(id), rsp_data <= mul_c, rsp_err <= mul_err. Otherwise rsp_valid <= 0 and rsp_data/rsp_err hold.
- Latency: grant in cycle t → rsp_valid high in cycle t+LAT+1 (t+3 by default) for exactly one cycle. Requesters have no backpressure and must accept the response.
- inflight:
  - +1 on a grant, -1 when rsp_valid is registered; both in the same cycle leaves it unchanged.
  - Never exceeds LAT+1; this is covered by an assertion.
- err_cnt: increments when a registered response has err = 1; saturates at 2^ECW-1.
- Requester changes: a requester deasserting req mid-cycle without a grant is legal. A changing req_a/req_b is legal until the grant cycle.

Test Plan:
- Reset, then en = 1, req = 0001, A = 0x40000000 (2.0), B = 0x40400000 (3.0) → gnt = 0001 in cycle 0; rsp_valid = 0001 and rsp_data = 0x40C00000 (6.0) in cycle 3; inflight returns to 0.
- req = 1111 held for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses follow in the same order, 3 cycles later, with no gaps.
- Overflow operands (0x7F000000 × 0x7F000000) from requester 2 → rsp_valid = 0100, rsp_err = 1, err_cnt = 1; 2^ECW such responses leave err_cnt at 0xFFFF.
- en dropped during back-to-back issue → no grants from the next cycle, the outstanding 2 responses still delivered, then idle = 1; raising en in DRAIN returns to RUN with no idle pulse.
- rst_n pulsed low with inflight = 2 → all outputs are at reset values immediately and no rsp_valid appears afterward.
- req = 0101 with rr_ptr = 1 → grant 2 first, then 0 (wrap-around).

Source files
------------

// File: rtl/fmul_arbiter_if.sv
// Requester-side bundle of the shared-multiplier arbiter: packed request
// operands in, one-hot grant and one-hot response strobe out.
//
// Handshake: a requester holds req[i] (with stable operands) until gnt[i] is
// seen; gnt[i] high consumes the request in that same cycle. The response is a
// single-cycle rsp_valid[i] strobe with rsp_data/rsp_err and no backpressure,
// so the requester must take it when it appears.
interface fmul_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]    req;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic            rsp_err;

    modport master (
        output req, req_a, req_b,
        input  gnt, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req, req_a, req_b,
        output gnt, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one pipelined fp32 multiplier among N requesters,
// with ID-tagged result return, enable/drain sequencing and an error counter.
module fmul_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int LAT = 2,
    parameter int ECW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    fmul_arbiter_if.slave     bus,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [31:0]       mul_c,
    input  logic              mul_err,
    output logic              idle,
    output logic [1:0]        inflight,
    output logic [ECW-1:0]    err_cnt,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             grant_ok;
    logic             gnt_any;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   rr_ptr;
    logic [LAT-1:0]   tag_v;
    logic [IDW-1:0]   tag_id [LAT];
    logic [N-1:0]     rsp_oh;
    logic             rsp_due;

    assign state_dbg = state;
    assign rsp_due   = tag_v[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // en always wins back RUN, so a brief en drop during DRAIN never idles.
    always_comb begin
        state_nxt = state;
        grant_ok  = 1'b0;
        case (state)
            ST_STOP: begin
                if (en) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                grant_ok = 1'b1;
                if (!en) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end else if (tag_v == '0 && inflight == 2'd0) begin
                    state_nxt = ST_STOP;
                end
            end
            default: state_nxt = ST_STOP;
        endcase
    end

    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (grant_ok && !gnt_any && bus.req[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        bus.gnt = '0;
        mul_a   = '0;
        mul_b   = '0;
        if (gnt_any) begin
            bus.gnt[gnt_id] = 1'b1;
            mul_a = bus.req_a[32*gnt_id +: 32];
            mul_b = bus.req_b[32*gnt_id +: 32];
        end
    end

    always_comb begin
        rsp_oh = '0;
        rsp_oh[tag_id[LAT-1]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            tag_v  <= '0;
            for (int s = 0; s < LAT; s++) tag_id[s] <= '0;
        end else begin
            if (gnt_any) begin
                rr_ptr <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
            end
            tag_v[0]  <= gnt_any;
            tag_id[0] <= gnt_id;
            for (int s = 1; s < LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    // mul_c/mul_err belong to the id in the last tag stage; register them out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            err_cnt       <= '0;
        end else begin
            if (rsp_due) begin
                bus.rsp_valid <= rsp_oh;
                bus.rsp_data  <= mul_c;
                bus.rsp_err   <= mul_err;
                if (mul_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end else begin
                bus.rsp_valid <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 2'd0;
            idle     <= 1'b1;
        end else begin
            case ({gnt_any, rsp_due})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: inflight <= inflight;
            endcase
            idle <= (state_nxt == ST_STOP);
        end
    end

    a_inflight_bound: assert property (
        @(posedge clk) disable iff (!rst_n) (32'(inflight) <= LAT + 1)
    );

endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter: a stub fp32 multiplier, a cycle-level
// reference model with an expected-response queue, and per-scenario tasks.
module tb_fmul_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = 2;
    localparam int ECW = 6;
    localparam int EW  = 33 + IDW;
    localparam logic [ECW-1:0] ERR_MAX = '1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [31:0]    mul_a, mul_b, mul_c;
    logic           mul_err;
    logic           idle;
    logic [1:0]     inflight;
    logic [ECW-1:0] err_cnt;
    logic [1:0]     state_dbg;

    always #5 clk = ~clk;

    fmul_arbiter_if #(.N(N)) bus ();

    fmul_arbiter #(.N(N), .IDW(IDW), .LAT(LAT), .ECW(ECW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(bus),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_err(mul_err),
        .idle(idle), .inflight(inflight), .err_cnt(err_cnt), .state_dbg(state_dbg)
    );

    // Truncating fp32 multiply; denormal inputs read as zero, over/underflow flag an error.
    function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {1'b0, s, 31'b0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'b0};
        if (e <= 0) return {1'b1, s, 31'b0};
        return {1'b0, s, e[7:0], m};
    endfunction

    logic [32:0] p0, p1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0 <= '0;
            p1 <= '0;
        end else begin
            p0 <= fmul(mul_a, mul_b);
            p1 <= p0;
        end
    end
    assign mul_c   = p1[31:0];
    assign mul_err = p1[32];

    int total = 0;
    int bad = 0;

    logic [N-1:0]   pend = '0;
    logic [31:0]    opa [N];
    logic [31:0]    opb [N];

    logic [N-1:0]   s_gnt, s_rsp_valid;
    logic [31:0]    s_rsp_data, s_mul_a;
    logic           s_rsp_err, s_idle;
    logic [1:0]     s_inflight;
    logic [ECW-1:0] s_err_cnt;

    logic [EW-1:0]  exp_q[$];
    int             due_q[$];
    int             m_cyc = 0;
    int             m_rr = 0;
    int             m_err = 0;
    logic           m_run = 1'b0;
    logic           m_idle = 1'b1;

    function automatic logic [31:0] rand_op();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    task automatic drive();
        bus.req = pend;
        for (int i = 0; i < N; i++) begin
            bus.req_a[32*i +: 32] = opa[i];
            bus.req_b[32*i +: 32] = opb[i];
        end
    endtask

    task automatic request(input int i, input logic [31:0] a, input logic [31:0] b);
        if (!pend[i]) begin
            pend[i] = 1'b1;
            opa[i]  = a;
            opb[i]  = b;
        end
    endtask

    // One clock: sample at the falling edge, run the reference model and
    // scoreboard, then after the rising edge retire granted requests and redrive.
    task automatic tick();
        logic [EW-1:0] e;
        logic [N-1:0]  oh, exp_gnt;
        logic [32:0]   r;
        logic [63:0]   exp_ab;
        int gid, idx, pending;
        @(negedge clk);
        s_gnt = bus.gnt;  s_rsp_valid = bus.rsp_valid;  s_rsp_data = bus.rsp_data;
        s_rsp_err = bus.rsp_err;  s_idle = idle;  s_inflight = inflight;
        s_err_cnt = err_cnt;  s_mul_a = mul_a;
        m_cyc++;
        if (!rst_n) begin
            exp_q.delete();  due_q.delete();
            m_run = 1'b0;  m_idle = 1'b1;  m_rr = 0;  m_err = 0;
        end else begin
            if (due_q.size() > 0 && due_q[0] == m_cyc) begin
                e = exp_q.pop_front();
                void'(due_q.pop_front());
                oh = '0;
                oh[e[32 +: IDW]] = 1'b1;
                total++;
                if (s_rsp_valid !== oh || s_rsp_data !== e[31:0] || s_rsp_err !== e[EW-1]) begin
                    bad++;
                    $display("FAIL sb_rsp cyc=%0d got v=%b d=%h e=%b want v=%b d=%h e=%b", m_cyc,
                             s_rsp_valid, s_rsp_data, s_rsp_err, oh, e[31:0], e[EW-1]);
                end
                if (e[EW-1] && m_err < int'(ERR_MAX)) m_err++;
            end else begin
                total++;
                if (s_rsp_valid !== '0) begin
                    bad++;
                    $display("FAIL sb_no_rsp cyc=%0d got=%b want=0", m_cyc, s_rsp_valid);
                end
            end
            total++;
            if (s_inflight !== 2'(exp_q.size())) begin
                bad++;
                $display("FAIL sb_inflight cyc=%0d got=%0d want=%0d", m_cyc, s_inflight, exp_q.size());
            end
            total++;
            if (s_idle !== m_idle) begin
                bad++;
                $display("FAIL sb_idle cyc=%0d got=%b want=%b", m_cyc, s_idle, m_idle);
            end
            total++;
            if (s_err_cnt !== ECW'(m_err)) begin
                bad++;
                $display("FAIL sb_err_cnt cyc=%0d got=%0d want=%0d", m_cyc, s_err_cnt, m_err);
            end
            pending = exp_q.size();
            gid = -1;
            if (m_run) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (gid < 0 && bus.req[idx]) gid = idx;
                end
            end
            exp_gnt = '0;
            exp_ab  = '0;
            if (gid >= 0) begin
                exp_gnt[gid] = 1'b1;
                exp_ab = {bus.req_a[32*gid +: 32], bus.req_b[32*gid +: 32]};
            end
            total++;
            if (s_gnt !== exp_gnt) begin
                bad++;
                $display("FAIL sb_gnt cyc=%0d got=%b want=%b", m_cyc, s_gnt, exp_gnt);
            end
            total++;
            if ({mul_a, mul_b} !== exp_ab) begin
                bad++;
                $display("FAIL sb_mul_ops cyc=%0d got=%h want=%h", m_cyc, {mul_a, mul_b}, exp_ab);
            end
            if (gid >= 0) begin
                r = fmul(exp_ab[63:32], exp_ab[31:0]);
                exp_q.push_back({r[32], IDW'(gid), r[31:0]});
                due_q.push_back(m_cyc + LAT + 1);
                m_rr = (gid + 1) % N;
            end
            m_idle = !en && (m_idle || (!m_run && pending == 0));
            m_run  = en;
        end
        @(posedge clk);
        #1;
        pend = pend & ~s_gnt;
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;  en = 1'b0;  pend = '0;
        drive();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        drive();
        tick();
        total++;
        if (s_gnt !== '0 || s_mul_a !== '0 || s_rsp_valid !== '0) begin
            bad++;
            $display("FAIL reset_gnt_rsp got gnt=%b a=%h v=%b want 0", s_gnt, s_mul_a, s_rsp_valid);
        end
        total++;
        if (s_rsp_data !== '0 || s_rsp_err !== 1'b0 || s_inflight !== 2'd0 || s_err_cnt !== '0) begin
            bad++;
            $display("FAIL reset_regs got d=%h e=%b inf=%0d ec=%0d want 0", s_rsp_data, s_rsp_err, s_inflight, s_err_cnt);
        end
        total++;
        if (s_idle !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle got=%b want=1", s_idle);
        end
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_basic();
        int n;
        en = 1'b1;
        tick();
        request(0, 32'h40000000, 32'h40400000);
        drive();
        tick();
        total++;
        if (s_gnt !== 4'b0001) begin
            bad++;
            $display("FAIL basic_gnt got=%b want=0001", s_gnt);
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (s_rsp_valid === '0 && n < 8);
        total++;
        if (n !== 3 || s_rsp_valid !== 4'b0001 || s_rsp_data !== 32'h40C00000) begin
            bad++;
            $display("FAIL basic_rsp got lat=%0d v=%b d=%h want lat=3 v=0001 d=40c00000", n, s_rsp_valid, s_rsp_data);
        end
        tick();
        total++;
        if (s_inflight !== 2'd0) begin
            bad++;
            $display("FAIL basic_inflight got=%0d want=0", s_inflight);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] want;
        do_reset();
        en = 1'b1;
        tick();
        for (int t = 0; t < 12; t++) begin
            if (t < 8) begin
                for (int i = 0; i < N; i++) request(i, rand_op(), rand_op());
            end else begin
                pend = '0;
            end
            drive();
            tick();
            if (t < 8) begin
                want = '0;
                want[t % N] = 1'b1;
                total++;
                if (s_gnt !== want) begin
                    bad++;
                    $display("FAIL b2b_gnt t=%0d got=%b want=%b", t, s_gnt, want);
                end
            end
            if (t >= 3 && t < 11) begin
                want = '0;
                want[(t - 3) % N] = 1'b1;
                total++;
                if (s_rsp_valid !== want) begin
                    bad++;
                    $display("FAIL b2b_rsp t=%0d got=%b want=%b", t, s_rsp_valid, want);
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        en = 1'b1;
        tick();
        request(0, rand_op(), rand_op());
        drive();
        tick();
        request(0, rand_op(), rand_op());
        request(2, rand_op(), rand_op());
        drive();
        tick();
        total++;
        if (s_gnt !== 4'b0100) begin
            bad++;
            $display("FAIL wrap_first got=%b want=0100", s_gnt);
        end
        tick();
        total++;
        if (s_gnt !== 4'b0001) begin
            bad++;
            $display("FAIL wrap_second got=%b want=0001", s_gnt);
        end
        repeat (4) tick();
    endtask

    task automatic test_err_sat();
        int n;
        do_reset();
        en = 1'b1;
        tick();
        request(2, 32'h7F000000, 32'h7F000000);
        drive();
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (s_rsp_valid === '0 && n < 8);
        total++;
        if (s_rsp_valid !== 4'b0100 || s_rsp_err !== 1'b1) begin
            bad++;
            $display("FAIL err_rsp got v=%b e=%b want v=0100 e=1", s_rsp_valid, s_rsp_err);
        end
        tick();
        total++;
        if (s_err_cnt !== ECW'(1)) begin
            bad++;
            $display("FAIL err_cnt_one got=%0d want=1", s_err_cnt);
        end
        for (int k = 0; k < 70; k++) begin
            request(2, 32'h7F000000, 32'h7F000000);
            drive();
            tick();
        end
        pend = '0;
        drive();
        repeat (5) tick();
        total++;
        if (s_err_cnt !== ERR_MAX) begin
            bad++;
            $display("FAIL err_cnt_sat got=%0d want=%0d", s_err_cnt, ERR_MAX);
        end
    endtask

    task automatic test_drain();
        int nrsp, idle_at, n;
        logic got_gnt;
        do_reset();
        en = 1'b1;
        tick();
        nrsp = 0;
        idle_at = -1;
        for (int t = 0; t < 14; t++) begin
            if (t < 5) begin
                for (int i = 0; i < N; i++) request(i, rand_op(), rand_op());
            end else begin
                pend = '0;
            end
            if (t == 4) en = 1'b0;
            drive();
            tick();
            if (t == 4) begin
                total++;
                if (s_gnt === '0) begin
                    bad++;
                    $display("FAIL drain_fall_gnt got=%b want nonzero", s_gnt);
                end
            end
            if (t == 5) begin
                total++;
                if (s_gnt !== '0) begin
                    bad++;
                    $display("FAIL drain_no_gnt got=%b want=0", s_gnt);
                end
            end
            if (t >= 5 && s_rsp_valid !== '0) nrsp++;
            if (idle_at < 0 && s_idle === 1'b1) idle_at = t;
        end
        // Two operations in flight plus the one granted as en falls.
        total++;
        if (nrsp !== 3) begin
            bad++;
            $display("FAIL drain_rsp_count got=%0d want=3", nrsp);
        end
        total++;
        if (idle_at !== 8) begin
            bad++;
            $display("FAIL drain_idle_at got=%0d want=8", idle_at);
        end
        en = 1'b1;
        drive();
        tick();
        got_gnt = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (t < 6) begin
                for (int i = 0; i < N; i++) request(i, rand_op(), rand_op());
            end else begin
                pend = '0;
            end
            en = (t != 3);
            drive();
            tick();
            total++;
            if (s_idle !== 1'b0) begin
                bad++;
                $display("FAIL rerun_idle t=%0d got=%b want=0", t, s_idle);
            end
            if (t == 5) got_gnt = (s_gnt !== '0);
        end
        total++;
        if (!got_gnt) begin
            bad++;
            $display("FAIL rerun_gnt got=0 want=1");
        end
        en = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (s_idle !== 1'b1 && n < 12);
        total++;
        if (s_idle !== 1'b1) begin
            bad++;
            $display("FAIL rerun_final_idle got=%b want=1", s_idle);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        en = 1'b1;
        tick();
        request(0, rand_op(), rand_op());
        request(1, rand_op(), rand_op());
        drive();
        tick();
        tick();
        total++;
        if (inflight !== 2'd2) begin
            bad++;
            $display("FAIL rst_pre_inflight got=%0d want=2", inflight);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.gnt !== '0 || mul_a !== '0 || mul_b !== '0 || bus.rsp_valid !== '0 || bus.rsp_data !== '0 ||
            bus.rsp_err !== 1'b0 || inflight !== 2'd0 || idle !== 1'b1 || err_cnt !== '0) begin
            bad++;
            $display("FAIL rst_async got gnt=%b v=%b d=%h inf=%0d idle=%b ec=%0d want reset values",
                     bus.gnt, bus.rsp_valid, bus.rsp_data, inflight, idle, err_cnt);
        end
        en = 1'b0;
        pend = '0;
        drive();
        tick();
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            total++;
            if (s_rsp_valid !== '0) begin
                bad++;
                $display("FAIL rst_dropped t=%0d got=%b want=0", t, s_rsp_valid);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_err_sat();
        test_drain();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
